// File: rtl/change_dispenser_pkg.sv
// vend_pkg: shared types and constants for the change dispenser.
package vend_pkg;
    localparam int CHANGE_W = 3;
    typedef logic [CHANGE_W-1:0] change_t;
    localparam change_t NICKEL = CHANGE_W'(1);
    localparam change_t DIME   = CHANGE_W'(2);
    localparam change_t MAX_CHANGE = CHANGE_W'(4);
    typedef enum logic [1:0] {IDLE, VEND, PAY, COIN} state_e;
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: vend request, hopper handshake and status signals of the dispenser.
interface change_dispenser_if;
    import vend_pkg::*;
    logic    soda_i;
    change_t change_i;
    logic    hopper_ready_i;
    logic    refill_i;
    logic    vend_o;
    logic    nickel_o;
    logic    dime_o;
    logic    busy_o;
    logic    overflow_o;
    logic    short_o;
    modport master (
        output soda_i, change_i, hopper_ready_i, refill_i,
        input  vend_o, nickel_o, dime_o, busy_o, overflow_o, short_o
    );
    modport slave (
        input  soda_i, change_i, hopper_ready_i, refill_i,
        output vend_o, nickel_o, dime_o, busy_o, overflow_o, short_o
    );
endinterface

// File: rtl/change_dispenser_fifo.sv
// req_fifo: circular queue of DEPTH pending change amounts with full/empty flags.
module req_fifo
    import vend_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    reset_i,
    input  logic    push_i,
    input  logic    pop_i,
    input  change_t data_i,
    output change_t data_o,
    output logic    full_o,
    output logic    empty_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    change_t mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0] cnt_q, cnt_d;
    always_comb begin
        rd_d  = pop_i ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
        wr_d  = push_i ? (wr_q == LAST ? '0 : wr_q + 1'b1) : wr_q;
        cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
    // A write into the slot being read this cycle is safe: the read is combinational.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end
    assign data_o  = mem_q[rd_q];
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: queues vend requests, pulses the soda motor, then pays change coin by coin.
// Define INVENTORY_EN to track finite nickel/dime stock with refill and short-change reporting.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int INIT_NICKELS = 8,
    parameter int INIT_DIMES   = 8
) (
    input logic clk_i,
    input logic reset_i,
    change_dispenser_if.slave bus
);
    state_e  state_q, state_d;
    change_t rem_q, rem_d, head, req;
    logic    dime_q, dime_d, ovf_q;
    logic    full, empty, push, pop, take;
    logic    have_dime, have_nickel, can_dime, no_coin;
    assign req      = bus.change_i > MAX_CHANGE ? '0 : bus.change_i;
    assign pop      = state_q == IDLE && !empty;
    assign push     = bus.soda_i && !reset_i && (!full || pop);
    assign take     = state_q == COIN && bus.hopper_ready_i;
    assign can_dime = rem_q >= DIME && have_dime;
    req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (req),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );
`ifdef INVENTORY_EN
    logic [3:0] nickels_q, dimes_q;
    always_ff @(posedge clk_i) begin
        if (reset_i || bus.refill_i) begin
            nickels_q <= 4'(INIT_NICKELS);
            dimes_q   <= 4'(INIT_DIMES);
        end else if (take) begin
            if (dime_q && dimes_q != '0) dimes_q <= dimes_q - 1'b1;
            if (!dime_q && nickels_q != '0) nickels_q <= nickels_q - 1'b1;
        end
    end
    assign have_dime   = dimes_q != '0;
    assign have_nickel = nickels_q != '0;
    assign no_coin     = !can_dime && !have_nickel;
`else
    assign have_dime   = 1'b1;
    assign have_nickel = 1'b1;
    assign no_coin     = 1'b0;
`endif
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dime_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dime_q  <= dime_d;
            ovf_q   <= bus.soda_i && full && !pop;
        end
    end
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dime_d  = dime_q;
        case (state_q)
            IDLE: if (!empty) begin
                state_d = VEND;
                rem_d   = head;
            end
            VEND: state_d = PAY;
            PAY: if (rem_q == '0) begin
                state_d = IDLE;
            end else if (can_dime || have_nickel) begin
                state_d = COIN;
                dime_d  = can_dime;
            end else begin
                state_d = IDLE;
                rem_d   = '0;
            end
            COIN: if (take) begin
                state_d = PAY;
                rem_d   = rem_q - (dime_q ? DIME : NICKEL);
            end
        endcase
    end
    always_comb begin
        bus.vend_o     = state_q == VEND;
        bus.nickel_o   = state_q == COIN && !dime_q;
        bus.dime_o     = state_q == COIN && dime_q;
        bus.short_o    = state_q == PAY && rem_q != '0 && no_coin;
        bus.busy_o     = state_q != IDLE || !empty;
        bus.overflow_o = ovf_q;
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed vend/change scenarios, checked every cycle against a
// greedy change-making model plus hand-computed latency and coin-count expectations.
module tb_change_dispenser;
    import vend_pkg::*;
    localparam int DEPTH  = 2;
    localparam int INIT_N = 8;
    localparam int INIT_D = 8;
`ifdef INVENTORY_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif
    typedef enum int {S_QUIET, S_VEND, S_DIME, S_NICKEL, S_SHORT} step_e;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int passed = 0;
    int vend_cnt, coin_cyc, dime_hs, nick_hs, short_cnt, ovf_cnt;
    int q[$];
    step_e plan[$];
    step_e cur;
    int m_nick, m_dime;
    logic ovf_exp = 1'b0;

    change_dispenser_if bus();
    change_dispenser #(.DEPTH(DEPTH), .INIT_NICKELS(INIT_N), .INIT_DIMES(INIT_D)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );
    always #5 clk = ~clk;

    task automatic chk(string name, logic got, logic exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, exp);
    endtask

    // Expected per-cycle timeline of one transaction: vend, then a pay cycle before each coin.
    function automatic void build(int c);
        int r = c > 4 ? 0 : c;
        int n = m_nick;
        int d = m_dime;
        bit short_hit = 1'b0;
        plan.push_back(S_VEND);
        while (r > 0 && !short_hit) begin
            if (r >= 2 && (!INV || d > 0)) begin
                plan.push_back(S_QUIET); plan.push_back(S_DIME); r -= 2; d--;
            end else if (!INV || n > 0) begin
                plan.push_back(S_QUIET); plan.push_back(S_NICKEL); r--; n--;
            end else short_hit = 1'b1;
        end
        plan.push_back(short_hit ? S_SHORT : S_QUIET);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete(); plan.delete();
            m_nick = INIT_N; m_dime = INIT_D; ovf_exp = 1'b0;
        end else begin
            ovf_exp = 1'b0;
            if (plan.size() == 0) begin
                if (q.size() > 0) build(q.pop_front());
            end else if (plan[0] == S_DIME || plan[0] == S_NICKEL) begin
                if (bus.hopper_ready_i) begin
                    if (plan[0] == S_DIME) m_dime--; else m_nick--;
                    void'(plan.pop_front());
                end
            end else void'(plan.pop_front());
            if (INV && bus.refill_i) begin m_nick = INIT_N; m_dime = INIT_D; end
            if (bus.soda_i) begin
                if (q.size() < DEPTH) q.push_back(int'(bus.change_i));
                else ovf_exp = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        cur = plan.size() > 0 ? plan[0] : S_QUIET;
        chk("vend_o", bus.vend_o, cur == S_VEND);
        chk("dime_o", bus.dime_o, cur == S_DIME);
        chk("nickel_o", bus.nickel_o, cur == S_NICKEL);
        chk("short_o", bus.short_o, cur == S_SHORT);
        chk("busy_o", bus.busy_o, plan.size() > 0 || q.size() > 0);
        chk("overflow_o", bus.overflow_o, ovf_exp);
        vend_cnt  += int'(bus.vend_o);
        coin_cyc  += int'(bus.dime_o | bus.nickel_o);
        dime_hs   += int'(bus.dime_o & bus.hopper_ready_i);
        nick_hs   += int'(bus.nickel_o & bus.hopper_ready_i);
        short_cnt += int'(bus.short_o);
        ovf_cnt   += int'(bus.overflow_o);
    end

    task automatic step(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic clr();
        vend_cnt = 0; coin_cyc = 0; dime_hs = 0; nick_hs = 0; short_cnt = 0; ovf_cnt = 0;
    endtask
    task automatic soda(int c);
        bus.soda_i = 1'b1; bus.change_i = CHANGE_W'(c);
        step();
        bus.soda_i = 1'b0;
    endtask
    task automatic wait_idle(string name, int lim);
        int k = 0;
        while (bus.busy_o && k < lim) begin step(); k++; end
        chk(name, bus.busy_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr();
        bus.soda_i = 1'b1; bus.change_i = 3'd2; bus.hopper_ready_i = 1'b1; bus.refill_i = 1'b0;
        step(3);
        rst = 1'b0; bus.soda_i = 1'b0;
        chk("rst_vend", bus.vend_o, 1'b0);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_ovf", bus.overflow_o, 1'b0);
        step(2);
        chk("rst_soda_dropped", bus.busy_o, 1'b0);
        // change 0: vend at N+2, idle by N+4
        clr(); soda(0); step();
        chk("t1_vend_n2", bus.vend_o, 1'b1);
        step(2);
        chk("t1_idle_n4", bus.busy_o, 1'b0);
        chk("t1_no_coin", coin_cyc == 0, 1'b1);
        // change 5 is treated as 0
        clr(); soda(5); wait_idle("t1b_idle", 20);
        chk("t1b_vend", vend_cnt == 1, 1'b1);
        chk("t1b_no_coin", coin_cyc == 0, 1'b1);
        // change 3: dime at N+4, then nickel
        clr(); soda(3); step();
        chk("t2_vend_n2", bus.vend_o, 1'b1);
        step(2);
        chk("t2_dime_n4", bus.dime_o, 1'b1);
        wait_idle("t2_idle", 20);
        chk("t2_one_dime", dime_hs == 1, 1'b1);
        chk("t2_one_nickel", nick_hs == 1, 1'b1);
        // hopper stalls 5 cycles: dime held 6 cycles, one handshake
        clr(); bus.hopper_ready_i = 1'b0; soda(2); step(3);
        chk("t3_dime_n4", bus.dime_o, 1'b1);
        step(5);
        chk("t3_dime_held", bus.dime_o, 1'b1);
        bus.hopper_ready_i = 1'b1;
        wait_idle("t3_idle", 20);
        chk("t3_hold6", coin_cyc == 6, 1'b1);
        chk("t3_one_dec", dime_hs == 1, 1'b1);
        // three requests while busy with DEPTH=2: third overflows
        clr(); soda(4); step(2);
        soda(0); soda(0); soda(0);
        wait_idle("t4_idle", 80);
        chk("t4_one_ovf", ovf_cnt == 1, 1'b1);
        chk("t4_three_vends", vend_cnt == 3, 1'b1);
        // soda held high: overflow, and push+pop in the same cycle when full
        clr(); bus.soda_i = 1'b1; bus.change_i = 3'd1;
        step(10);
        bus.soda_i = 1'b0;
        wait_idle("t5_idle", 200);
        chk("t5_some_ovf", ovf_cnt > 0, 1'b1);
        // reset mid-COIN, with a coincident soda that must be discarded
        clr(); bus.hopper_ready_i = 1'b0; soda(2); step(3);
        chk("t6_coin_before_rst", bus.dime_o, 1'b1);
        rst = 1'b1; bus.soda_i = 1'b1;
        step();
        rst = 1'b0; bus.soda_i = 1'b0;
        chk("t6_dime_cleared", bus.dime_o, 1'b0);
        chk("t6_busy_cleared", bus.busy_o, 1'b0);
        bus.hopper_ready_i = 1'b1;
        step(2);
        chk("t6_soda_dropped", bus.busy_o, 1'b0);
`ifdef INVENTORY_EN
        // drain dimes, then nickels, then run short
        clr();
        repeat (4) begin soda(4); wait_idle("t7_idle_d", 40); end
        chk("t7_eight_dimes", dime_hs == 8, 1'b1);
        clr(); soda(4); wait_idle("t7_idle_n", 40);
        chk("t7_four_nickels", nick_hs == 4, 1'b1);
        chk("t7_no_dime", dime_hs == 0, 1'b1);
        clr(); soda(3); wait_idle("t7_idle_3", 40);
        chk("t7_three_nickels", nick_hs == 3, 1'b1);
        clr(); soda(2); wait_idle("t7_idle_s", 40);
        chk("t7_last_nickel", nick_hs == 1, 1'b1);
        chk("t7_short", short_cnt == 1, 1'b1);
        bus.refill_i = 1'b1; step(); bus.refill_i = 1'b0;
        // refill coincident with a dime handshake wins over the decrement
        clr(); soda(2); step(3);
        chk("t8_dime_after_refill", bus.dime_o, 1'b1);
        bus.refill_i = 1'b1; step(); bus.refill_i = 1'b0;
        wait_idle("t8_idle", 20);
        clr();
        repeat (4) begin soda(4); wait_idle("t8_idle_d", 40); end
        chk("t8_refill_wins", dime_hs == 8, 1'b1);
        chk("t8_no_short", short_cnt == 0, 1'b1);
`endif
        step(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning request-queue entries (1..4).
REQ-002 SHALL have parameter INIT_NICKELS, default 8, meaning nickel count loaded on reset/refill (0..15).
REQ-003 SHALL have parameter INIT_DIMES, default 8, meaning dime count loaded on reset/refill (0..15).
REQ-004 SHALL have port clk_i  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_i  in  1  synchronous, active-high reset.
REQ-006 SHALL have port soda_i  in  1  one-cycle vend request from vending FSM.
REQ-007 SHALL have port change_i  in  3  change owed in nickel units (0..4), sampled with soda_i.
REQ-008 SHALL have port hopper_ready_i  in  1  hopper accepts the presented coin this cycle.
REQ-009 SHALL have port refill_i  in  1  reload inventory to INIT values.
REQ-010 SHALL have port vend_o  out  1  one-cycle soda motor pulse.
REQ-011 SHALL have port nickel_o  out  1  nickel request to hopper, held until accepted.
REQ-012 SHALL have port dime_o  out  1  dime request to hopper, held until accepted.
REQ-013 SHALL have port busy_o  out  1  high when state != IDLE or queue non-empty.
REQ-014 SHALL have port overflow_o  out  1  one-cycle pulse: request dropped, queue full.
REQ-015 SHALL have port short_o  out  1  one-cycle pulse: remaining change unpayable, abandoned.

Function
REQ-016 SHALL push change_i into the FIFO on a clock edge where soda_i=1 and the queue is not full; push and pop in the same cycle SHALL both take effect.
REQ-017 SHALL drop the request and pulse overflow_o the following cycle when soda_i=1 and the queue is full with no same-cycle pop.
REQ-018 SHALL treat change_i values 5..7 as 0 (vend only, no change).
REQ-019 SHALL implement states IDLE, VEND, PAY, COIN; IDLE pops when queue non-empty, loading remaining (3 bits), next state VEND.
REQ-020 SHALL assert vend_o for exactly the one cycle in VEND; next state PAY.
REQ-021 PAY SHALL go IDLE if remaining=0; else select dime if remaining>=2 and dimes>0, else nickel if nickels>0, latch selection, go COIN; else pulse short_o, clear remaining, go IDLE.
REQ-022 COIN SHALL hold the latched coin output high and stable until a cycle with hopper_ready_i=1, then subtract 2 (dime) or 1 (nickel) from remaining, decrement that inventory, return to PAY.
REQ-023 nickel_o and dime_o SHALL never be high simultaneously, and SHALL be low outside COIN.
REQ-024 Latency: soda_i high in cycle N SHALL produce vend_o in cycle N+2 when idle with empty queue; first coin output in N+4.
REQ-025 refill_i SHALL load both counts with INIT values; if coincident with a handshake decrement, refill wins.
REQ-026 Inventory counters SHALL be 4 bits and SHALL never underflow.

Reset
REQ-027 reset_i SHALL, at the next edge, set state IDLE, empty queue, remaining=0, counts to INIT values, and drive all outputs 0, including mid-COIN.
REQ-028 soda_i coincident with reset_i SHALL be discarded.

Configuration
REQ-029 With INVENTORY_EN defined, inventory SHALL be tracked per REQ-021/025/026.
REQ-030 Without INVENTORY_EN, counters and refill_i logic SHALL be absent, inventory treated as unlimited, short_o tied 0.

Structure
REQ-031 Package vend_pkg SHALL hold the state enum, CHANGE_W=3, coin values in nickel units (NICKEL=1, DIME=2).
REQ-032 The queue SHALL be a sub-module req_fifo (DEPTH x CHANGE_W, full/empty flags).

Verification
REQ-033 soda_i with change_i=0 -> vend_o cycle N+2, no coin outputs, busy_o low by N+4.
REQ-034 change_i=3, hopper_ready_i=1 -> vend_o, then one dime then one nickel, dimes 8->7, nickels 8->7.
REQ-035 INIT_DIMES=0, change_i=4 -> four nickel_o handshakes, nickels 8->4.
REQ-036 hopper_ready_i low 5 cycles during COIN -> dime_o held stable 6 cycles, exactly one decrement.
REQ-037 Three back-to-back soda_i while busy, DEPTH=2 -> third request raises overflow_o, two vends follow.
REQ-038 INIT_NICKELS=0, INIT_DIMES=0, change_i=1 -> vend_o then short_o, no coin outputs.
